// File: rtl/apb_slave_regbank.sv
// APB4 completer with a parametrised register bank, fixed wait states, byte-lane
// writes, error signalling and a read-only ID word at index 0.
module apb_slave_regbank #(
  parameter int              ADDR_WIDTH  = 8,
  parameter int              DATA_WIDTH  = 32,
  parameter int              NUM_REGS    = 16,
  parameter int              WAIT_STATES = 0,
  parameter logic [63:0]     ID_VALUE    = 64'hA9B0_0001
) (
  input  logic                    i_pclk,
  input  logic                    i_rst_n,
  input  logic [ADDR_WIDTH-1:0]   i_paddr,
  input  logic                    i_psel,
  input  logic                    i_penable,
  input  logic                    i_pwrite,
  input  logic [DATA_WIDTH-1:0]   i_pwdata,
  input  logic [DATA_WIDTH/8-1:0] i_pstrb,
  output logic                    o_pready,
  output logic [DATA_WIDTH-1:0]   o_prdata,
  output logic                    o_pslverr
);

  localparam int              NUM_LANES  = DATA_WIDTH / 8;
  localparam int              ADDR_LSB   = $clog2(NUM_LANES);
  localparam int              IDX_W      = ADDR_WIDTH - ADDR_LSB;
  localparam logic [31:0]     NUM_REGS_U = NUM_REGS;
  localparam logic [3:0]      WS         = 4'(WAIT_STATES);
  localparam logic [DATA_WIDTH-1:0] ID_WORD = ID_VALUE[DATA_WIDTH-1:0];

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_next;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_err;
  logic                  r_write;
  logic                  r_pready;
  logic                  r_pslverr;
  logic [DATA_WIDTH-1:0] r_prdata;

  logic [IDX_W-1:0]      w_idx;
  logic                  w_misalign;
  logic                  w_range_err;
  logic                  w_err_live;
  logic                  w_setup;
  logic                  w_rsp;
  logic                  w_rsp_err;
  logic                  w_rsp_write;
  logic [IDX_W-1:0]      w_rsp_idx;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_wr_fire;
  logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];

  assign w_idx = i_paddr[ADDR_WIDTH-1:ADDR_LSB];

  generate
    if (ADDR_LSB > 0) begin : g_align
      assign w_misalign = |i_paddr[ADDR_LSB-1:0];
    end else begin : g_no_align
      assign w_misalign = 1'b0;
    end
  endgenerate

  assign w_range_err = (32'(w_idx) >= NUM_REGS_U);
  assign w_err_live  = w_range_err | w_misalign | (i_pwrite & (w_idx == '0));
  assign w_setup     = i_psel & ~i_penable;

  // With zero wait states the response is launched at the setup edge, so the
  // live decode is used; otherwise the decode captured at setup is used.
  assign w_rsp_err   = (r_state == ST_IDLE) ? w_err_live : r_err;
  assign w_rsp_write = (r_state == ST_IDLE) ? i_pwrite   : r_write;
  assign w_rsp_idx   = (r_state == ST_IDLE) ? w_idx      : r_idx;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_rsp        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_setup) begin
          w_state_next = ST_ACCESS;
          w_cnt_next   = WS;
          if (WS == 4'd0) begin
            w_rsp = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        if (i_psel && i_penable) begin
          if (r_pready) begin
            w_state_next = ST_IDLE;
          end else if (r_cnt > 4'd1) begin
            w_cnt_next = r_cnt - 4'd1;
          end else begin
            w_cnt_next = 4'd0;
            w_rsp      = 1'b1;
          end
        end else begin
          w_state_next = ST_IDLE;
          w_cnt_next   = 4'd0;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_rsp_idx == IDX_W'(i)) begin
        w_rd_data = w_regs[i];
      end
    end
  end

  // The write lands on the completion edge, while pready is visible to the requester.
  assign w_wr_fire = (r_state == ST_ACCESS) & r_pready & i_psel & i_penable & r_write & ~r_err;

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_idx     <= '0;
      r_err     <= 1'b0;
      r_write   <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      if (r_state == ST_IDLE && w_setup) begin
        r_idx   <= w_idx;
        r_err   <= w_err_live;
        r_write <= i_pwrite;
      end
      r_pready  <= w_rsp;
      r_pslverr <= w_rsp & w_rsp_err;
      r_prdata  <= (w_rsp && !w_rsp_err && !w_rsp_write) ? w_rd_data : '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_id
        assign w_regs[gi] = ID_WORD;
      end else begin : g_rw
        logic [DATA_WIDTH-1:0] r_reg;
        always_ff @(posedge i_pclk or negedge i_rst_n) begin
          if (!i_rst_n) begin
            r_reg <= '0;
          end else if (w_wr_fire && (r_idx == IDX_W'(gi))) begin
            for (int b = 0; b < NUM_LANES; b++) begin
              if (i_pstrb[b]) begin
                r_reg[b*8 +: 8] <= i_pwdata[b*8 +: 8];
              end
            end
          end
        end
        assign w_regs[gi] = r_reg;
      end
    end
  endgenerate

  assign o_pready  = r_pready;
  assign o_pslverr = r_pslverr;
  assign o_prdata  = r_prdata;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench: one zero-wait instance and one three-wait-state instance
// sharing clock, reset and bus data, with separate select lines.
module tb_apb_slave_regbank;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] paddr;
  logic          psel0, psel3, penable, pwrite;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic          pready0, pslverr0, pready3, pslverr3;
  logic [DW-1:0] prdata0, prdata3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  apb_slave_regbank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(16), .WAIT_STATES(0)) dut0 (
    .i_pclk(clk), .i_rst_n(rst_n), .i_paddr(paddr), .i_psel(psel0), .i_penable(penable),
    .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_pready(pready0), .o_prdata(prdata0), .o_pslverr(pslverr0));

  apb_slave_regbank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(16), .WAIT_STATES(3)) dut3 (
    .i_pclk(clk), .i_rst_n(rst_n), .i_paddr(paddr), .i_psel(psel3), .i_penable(penable),
    .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_pready(pready3), .o_prdata(prdata3), .o_pslverr(pslverr3));

  function automatic logic sel_pready(input bit u3);
    return u3 ? pready3 : pready0;
  endfunction
  function automatic logic sel_pslverr(input bit u3);
    return u3 ? pslverr3 : pslverr0;
  endfunction
  function automatic logic [DW-1:0] sel_prdata(input bit u3);
    return u3 ? prdata3 : prdata0;
  endfunction

  task automatic drive_setup(input bit u3, input bit wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [SW-1:0] s);
    @(negedge clk);
    psel0 = !u3; psel3 = u3; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = d; pstrb = s;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // Returns on the access cycle where pready is seen high; the bus is left
  // asserted so the completion edge follows.
  task automatic xfer(input bit u3, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [SW-1:0] s,
                      output logic [DW-1:0] rd, output logic err, output int lat);
    drive_setup(u3, wr, a, d, s);
    lat = 0; rd = '0; err = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      penable = 1'b1;
      if (sel_pready(u3)) begin
        lat = k; rd = sel_prdata(u3); err = sel_pslverr(u3);
        break;
      end
      checks++;
      if (sel_prdata(u3) !== '0 || sel_pslverr(u3) !== 1'b0) begin
        failures++;
        $display("FAIL wait_outputs_zero dut=%0d addr=0x%02h got prdata=0x%08h pslverr=%0b want 0/0",
                 u3 ? 3 : 0, a, sel_prdata(u3), sel_pslverr(u3));
      end
    end
    checks++;
    if (lat == 0) begin
      failures++;
      $display("FAIL pready_timeout dut=%0d addr=0x%02h got no pready in 20 cycles want pready", u3 ? 3 : 0, a);
    end
    $display("xfer dut=%0d %s addr=0x%02h wdata=0x%08h strb=%04b rdata=0x%08h err=%0b lat=%0d",
             u3 ? 3 : 0, wr ? "WR" : "RD", a, d, s, rd, err, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; psel0 = 0; psel3 = 0; penable = 0; pwrite = 0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({pready0, pslverr0, prdata0, pready3, pslverr3, prdata3} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got pready0=%0b pslverr0=%0b prdata0=0x%08h pready3=%0b pslverr3=%0b prdata3=0x%08h want all 0",
               pready0, pslverr0, prdata0, pready3, pslverr3, prdata3);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_id_read();
    logic [DW-1:0] rd; logic err; int lat;
    xfer(0, 0, 8'h00, '0, 4'h0, rd, err, lat);
    checks++;
    if (rd !== 32'hA9B00001 || err !== 1'b0 || lat != 1) begin
      failures++;
      $display("FAIL id_read got rd=0x%08h err=%0b lat=%0d want 0xa9b00001/0/1", rd, err, lat);
    end
    xfer(0, 0, 8'h04, '0, 4'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h0 || err !== 1'b0 || lat != 1) begin
      failures++;
      $display("FAIL reg1_reset_read got rd=0x%08h err=%0b lat=%0d want 0/0/1", rd, err, lat);
    end
    bus_idle();
    checks++;
    if (pready0 !== 1'b0 || prdata0 !== '0) begin
      failures++;
      $display("FAIL pready_drop got pready=%0b prdata=0x%08h want 0/0", pready0, prdata0);
    end
  endtask

  task automatic test_strobe();
    logic [DW-1:0] rd; logic err; int lat;
    xfer(0, 1, 8'h08, 32'hDEADBEEF, 4'hF, rd, err, lat);
    checks++;
    if (err !== 1'b0 || rd !== '0 || lat != 1) begin
      failures++;
      $display("FAIL write_full got err=%0b rd=0x%08h lat=%0d want 0/0/1", err, rd, lat);
    end
    xfer(0, 1, 8'h08, 32'h11223344, 4'b0101, rd, err, lat);
    xfer(0, 0, 8'h08, '0, 4'h0, rd, err, lat);
    checks++;
    if (rd !== 32'hDE22BE44 || err !== 1'b0) begin
      failures++;
      $display("FAIL strobe_merge got rd=0x%08h err=%0b want 0xde22be44/0", rd, err);
    end
    xfer(0, 1, 8'h3C, 32'h0F0F0F0F, 4'hF, rd, err, lat);
    xfer(0, 0, 8'h3C, '0, 4'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h0F0F0F0F || err !== 1'b0) begin
      failures++;
      $display("FAIL last_reg got rd=0x%08h err=%0b want 0x0f0f0f0f/0", rd, err);
    end
    bus_idle();
  endtask

  task automatic test_errors();
    logic [DW-1:0] rd; logic err; int lat;
    xfer(0, 1, 8'h40, 32'hFFFFFFFF, 4'hF, rd, err, lat);
    checks++;
    if (err !== 1'b1 || lat != 1) begin
      failures++;
      $display("FAIL err_range got err=%0b lat=%0d want 1/1", err, lat);
    end
    xfer(0, 0, 8'h06, '0, 4'h0, rd, err, lat);
    checks++;
    if (err !== 1'b1 || rd !== '0) begin
      failures++;
      $display("FAIL err_misalign got err=%0b rd=0x%08h want 1/0", err, rd);
    end
    xfer(0, 1, 8'h00, 32'h12345678, 4'hF, rd, err, lat);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_id_write got err=%0b want 1", err);
    end
    xfer(0, 0, 8'h40, '0, 4'h0, rd, err, lat);
    checks++;
    if (err !== 1'b1 || rd !== '0) begin
      failures++;
      $display("FAIL err_range_read got err=%0b rd=0x%08h want 1/0", err, rd);
    end
    xfer(0, 1, 8'h08, 32'hFFFFFFFF, 4'h0, rd, err, lat);
    checks++;
    if (err !== 1'b0 || lat != 1) begin
      failures++;
      $display("FAIL zero_strobe got err=%0b lat=%0d want 0/1", err, lat);
    end
    xfer(0, 0, 8'h00, '0, 4'h0, rd, err, lat);
    checks++;
    if (rd !== 32'hA9B00001 || err !== 1'b0) begin
      failures++;
      $display("FAIL id_unchanged got rd=0x%08h err=%0b want 0xa9b00001/0", rd, err);
    end
    xfer(0, 0, 8'h08, '0, 4'h0, rd, err, lat);
    checks++;
    if (rd !== 32'hDE22BE44 || err !== 1'b0) begin
      failures++;
      $display("FAIL reg2_unchanged got rd=0x%08h err=%0b want 0xde22be44/0", rd, err);
    end
    xfer(0, 0, 8'h3C, '0, 4'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h0F0F0F0F || err !== 1'b0) begin
      failures++;
      $display("FAIL reg15_unchanged got rd=0x%08h err=%0b want 0x0f0f0f0f/0", rd, err);
    end
    bus_idle();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] rd; logic err; int lat;
    xfer(1, 1, 8'h0C, 32'hCAFEF00D, 4'hF, rd, err, lat);
    checks++;
    if (lat != 4 || err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_write_ws3 got lat=%0d err=%0b want 4/0", lat, err);
    end
    xfer(1, 0, 8'h0C, '0, 4'h0, rd, err, lat);
    checks++;
    if (lat != 4 || rd !== 32'hCAFEF00D || err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_read_ws3 got lat=%0d rd=0x%08h err=%0b want 4/0xcafef00d/0", lat, rd, err);
    end
    xfer(0, 1, 8'h14, 32'h00C0FFEE, 4'hF, rd, err, lat);
    xfer(0, 0, 8'h14, '0, 4'h0, rd, err, lat);
    checks++;
    if (lat != 1 || rd !== 32'h00C0FFEE) begin
      failures++;
      $display("FAIL b2b_read_ws0 got lat=%0d rd=0x%08h want 1/0x00c0ffee", lat, rd);
    end
    bus_idle();
  endtask

  task automatic test_abort();
    logic [DW-1:0] rd; logic err; int lat; int seen;
    xfer(1, 1, 8'h10, 32'h55AA55AA, 4'hF, rd, err, lat);
    bus_idle();
    drive_setup(1, 1, 8'h10, 32'hFFFFFFFF, 4'hF);
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      penable = 1'b1;
      if (pready3 !== 1'b0) seen++;
    end
    @(negedge clk);
    psel3 = 1'b0; penable = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (pready3 !== 1'b0 || pslverr3 !== 1'b0 || prdata3 !== '0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_no_pready got %0d cycles with pready/outputs active want 0", seen);
    end
    xfer(1, 0, 8'h10, '0, 4'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h55AA55AA || err !== 1'b0 || lat != 4) begin
      failures++;
      $display("FAIL abort_old_value got rd=0x%08h err=%0b lat=%0d want 0x55aa55aa/0/4", rd, err, lat);
    end
    bus_idle();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd; logic err; int lat; int bad;
    xfer(1, 1, 8'h18, 32'h0BADF00D, 4'hF, rd, err, lat);
    xfer(1, 1, 8'h04, 32'h00000001, 4'hF, rd, err, lat);
    drive_setup(1, 0, 8'h10, '0, 4'h0);
    repeat (4) begin
      @(negedge clk);
      penable = 1'b1;
    end
    checks++;
    if (pready3 !== 1'b1 || prdata3 !== 32'h55AA55AA) begin
      failures++;
      $display("FAIL pre_reset_ready got pready=%0b prdata=0x%08h want 1/0x55aa55aa", pready3, prdata3);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (pready3 !== 1'b0 || prdata3 !== '0 || pslverr3 !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got pready=%0b prdata=0x%08h pslverr=%0b want 0/0/0", pready3, prdata3, pslverr3);
    end
    psel3 = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 1; i < 16; i++) begin
      xfer(1, 0, 8'(i * 4), '0, 4'h0, rd, err, lat);
      if (rd !== '0 || err !== 1'b0 || lat != 4) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL regs_cleared got %0d non-zero or bad reads want 0", bad);
    end
    xfer(1, 0, 8'h00, '0, 4'h0, rd, err, lat);
    checks++;
    if (rd !== 32'hA9B00001 || err !== 1'b0) begin
      failures++;
      $display("FAIL id_after_reset got rd=0x%08h err=%0b want 0xa9b00001/0", rd, err);
    end
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_id_read();
    test_strobe();
    test_errors();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_slave_regbank.md
Name: apb_slave_regbank

Overview:
- Parametrised APB4 completer; next generation of the fixed-width apb_slave used in hw_top.
- Adds configurable data width, register count and fixed wait-state insertion, plus PSTRB byte-lane writes, PSLVERR error signalling and a read-only ID register.
- Sits on the APB bus behind apb_if; drives pready, prdata and pslverr back to the requester.

Parameters:
- ADDR_WIDTH, 8, width of paddr in bits.
- DATA_WIDTH, 32, width of pwdata and prdata; legal values 8, 16, 32, 64.
- NUM_REGS, 16, number of word registers including the ID register; legal range 2 to 2^(ADDR_WIDTH-ADDR_LSB).
- WAIT_STATES, 0, access-phase cycles with pready=0 before completion; legal range 0 to 15.
- ID_VALUE, 'hA9B0_0001, constant read from register 0, truncated to DATA_WIDTH.

Ports:
- pclk  in  1  bus clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- paddr  in  ADDR_WIDTH  byte address.
- psel  in  1  slave select.
- penable  in  1  access-phase indicator.
- pwrite  in  1  1=write, 0=read.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  write byte strobes; ignored on reads.
- pready  out  1  transfer completion, registered.
- prdata  out  DATA_WIDTH  read data, registered.
- pslverr  out  1  transfer error, registered.

Behaviour:
- Reset (rst_n=0, any time, including mid-transfer): pready=0, prdata=0, pslverr=0, FSM=IDLE, wait counter=0. Registers 1..NUM_REGS-1 clear to 0. Register 0 always reads ID_VALUE.
- ADDR_LSB = log2(DATA_WIDTH/8).
- Register index = paddr[ADDR_WIDTH-1:ADDR_LSB].
- Address decode and error conditions:
  - Error if index >= NUM_REGS.
  - Error if paddr[ADDR_LSB-1:0] != 0 (only when ADDR_LSB > 0).
  - Error on any write to index 0.
- FSM states: IDLE, ACCESS.
- IDLE:
  - Enters ACCESS when psel=1 and penable=0 (setup cycle).
  - Captures the decode and error result.
  - Loads the wait counter with WAIT_STATES.
- ACCESS, with psel=1 and penable=1:
  - If counter > 0: decrement; pready stays 0.
  - If counter == 0: at this edge set pready=1, pslverr=error, prdata=(read and no error) ? register value : 0.
  - If no error, perform the write: byte lane i is updated only when pstrb[i]=1.
  - Next cycle: pready, pslverr and prdata return to 0; FSM returns to IDLE.
- Latency:
  - pready is high in the access cycle T+1+WAIT_STATES, where T is the setup cycle.
  - With WAIT_STATES=0, the transfer takes 2 cycles total, matching APB zero-wait timing.
- Back-to-back transfers: a setup cycle immediately following the completion cycle is accepted from IDLE with no idle gap.
- psel deasserted while in ACCESS (protocol abort): return to IDLE; no write; pready, pslverr and prdata stay 0.
- Address, control and pwdata must be stable through the access phase. Write data is sampled in the completion cycle.
- Outputs pslverr and prdata are 0 whenever pready=0.
- Read with error: prdata=0, pslverr=1.
- Writes with pstrb=0 and no error: complete with pready=1, pslverr=0, no state change.

Test Plan:
- Reset then read index 0 (paddr=0x00) -> prdata=0xA9B00001, pslverr=0. Read paddr=0x04 -> prdata=0.
- Write paddr=0x08, pwdata=0xDEADBEEF, pstrb=4'hF, then write pwdata=0x11223344, pstrb=4'b0101, then read -> prdata=0xDE22BE44.
- Write paddr=0x40 (index 16, out of range), read paddr=0x06 (misaligned), write paddr=0x00 (ID register) -> each completes with pslverr=1; read returns prdata=0; all registers unchanged.
- WAIT_STATES=3, back-to-back write then read of paddr=0x0C -> pready high exactly 4 cycles after each setup cycle; the read returns the written data; no idle cycle between the two transfers.
- Assert rst_n=0 mid-ACCESS with WAIT_STATES=3 after registers have been written -> pready=0 immediately; later reads of registers 1..15 return 0; register 0 reads 0xA9B00001.
- Drop psel during a wait state of a write to 0x10 -> pready never asserts; a subsequent read of 0x10 returns the old value.
